// File: rtl/ctrl_pkg.sv
// Shared defaults and FSM encoding for the loop-controller address path.
package ctrl_pkg;

    localparam int unsigned DEF_LOOP_ID_W   = 5;
    localparam int unsigned DEF_LOOP_ITER_W = 16;
    localparam int unsigned DEF_STRIDE_W    = 32;
    localparam int unsigned DEF_ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/controller_addr_adder_tree.sv
// Stage 2 of the address pipeline: base plus all per-loop products, registered with valid/last.
module controller_addr_adder_tree #(
    parameter int unsigned NUM_TERMS = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              flush,
    input  logic                              in_v,
    input  logic                              in_last,
    input  logic [NUM_TERMS-1:0][ADDR_W-1:0]  terms,
    input  logic [ADDR_W-1:0]                 base,
    output logic                              out_v,
    output logic [ADDR_W-1:0]                 sum,
    output logic                              out_last
);

    logic [ADDR_W-1:0] sum_c;

    always_comb begin
        sum_c = base;
        for (int i = 0; i < NUM_TERMS; i++) begin
            sum_c = sum_c + terms[i];
        end
    end

    // Address and last tag only move with a valid beat so they hold between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v    <= 1'b0;
            sum      <= '0;
            out_last <= 1'b0;
        end else if (flush) begin
            out_v <= 1'b0;
        end else if (en) begin
            out_v <= in_v;
            if (in_v) begin
                sum      <= sum_c;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/controller_addr_gen.sv
// Turns loop-iteration vectors into addresses: base + sum(iter[l]*stride[l]), two-stage pipeline.
module controller_addr_gen
    import ctrl_pkg::*;
#(
    parameter int unsigned LOOP_ID_W   = DEF_LOOP_ID_W,
    parameter int unsigned LOOP_ITER_W = DEF_LOOP_ITER_W,
    parameter int unsigned STRIDE_W    = DEF_STRIDE_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    localparam int unsigned NUM_MAX_LOOPS = 1 << LOOP_ID_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  stall,
    input  logic                                  cfg_base_v,
    input  logic [ADDR_W-1:0]                     cfg_base,
    input  logic                                  cfg_stride_v,
    input  logic [STRIDE_W-1:0]                   cfg_stride,
    input  logic [LOOP_ID_W-1:0]                  cfg_stride_id,
    input  logic                                  iter_v,
    input  logic                                  iter_last,
    input  logic [LOOP_ITER_W*NUM_MAX_LOOPS-1:0]  current_iters,
    output logic                                  addr_v,
    output logic [ADDR_W-1:0]                     addr,
    output logic                                  addr_last,
    output logic                                  done
);

    localparam int unsigned PROD_W = LOOP_ITER_W + STRIDE_W;

    state_e                                  state;
    logic [NUM_MAX_LOOPS-1:0][STRIDE_W-1:0]  stride_q;
    logic [ADDR_W-1:0]                       base_q;
    logic [NUM_MAX_LOOPS-1:0][ADDR_W-1:0]    prod_c;
    logic [NUM_MAX_LOOPS-1:0][ADDR_W-1:0]    prod1;
    logic [ADDR_W-1:0]                       base1;
    logic                                    v1;
    logic                                    last1;
    logic                                    accept_c;

    assign accept_c = (state == RUN) && iter_v && !stall && !start;

    always_comb begin
        for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
            prod_c[l] = ADDR_W'(PROD_W'(current_iters[LOOP_ITER_W*l +: LOOP_ITER_W]) *
                                PROD_W'(stride_q[l]));
        end
    end

    // Config registers: written in any state, survive across blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            stride_q <= '0;
        end else begin
            if (cfg_base_v) begin
                base_q <= cfg_base;
            end
            if (cfg_stride_v) begin
                stride_q[cfg_stride_id] <= cfg_stride;
            end
        end
    end

    // FSM and stage 1; base is captured with the sample so a later base write cannot skew it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            v1    <= 1'b0;
            last1 <= 1'b0;
            prod1 <= '0;
            base1 <= '0;
        end else if (start) begin
            state <= RUN;
            done  <= 1'b0;
            v1    <= 1'b0;
        end else if (stall) begin
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            v1   <= accept_c;
            if (accept_c) begin
                prod1 <= prod_c;
                base1 <= base_q;
                last1 <= iter_last;
            end
            case (state)
                RUN: begin
                    if (accept_c && iter_last) begin
                        state <= DRAIN;
                    end
                end
                // Stage 2 takes v1 on this edge, so v1==0 means both stages are empty afterwards.
                DRAIN: begin
                    if (!v1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    controller_addr_adder_tree #(
        .NUM_TERMS (NUM_MAX_LOOPS),
        .ADDR_W    (ADDR_W)
    ) u_adder_tree (
        .clk      (clk),
        .reset    (reset),
        .en       (!stall),
        .flush    (start),
        .in_v     (v1),
        .in_last  (last1),
        .terms    (prod1),
        .base     (base1),
        .out_v    (addr_v),
        .sum      (addr),
        .out_last (addr_last)
    );

endmodule

// File: tb/tb_controller_addr_gen.sv
// Scoreboard bench for controller_addr_gen with four loops.
module tb_controller_addr_gen;

    localparam int NL = 4;
    localparam int IW = 16;

    logic              clk = 1'b0;
    logic              reset, start, stall;
    logic              cfg_base_v, cfg_stride_v;
    logic [31:0]       cfg_base, cfg_stride;
    logic [1:0]        cfg_stride_id;
    logic              iter_v, iter_last;
    logic [IW*NL-1:0]  current_iters;
    logic              addr_v, addr_last, done;
    logic [31:0]       addr;

    typedef struct {
        logic [31:0] a;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] stride_m[NL];
    logic [31:0] base_m;
    bit          run_m;
    bit          froze;
    bit          exp_done;
    logic        prev_v, prev_last;
    logic [31:0] prev_addr;
    logic [31:0] last_seen;
    int          beats, done_cnt;
    int          total, bad;

    controller_addr_gen #(.LOOP_ID_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .cfg_base_v    (cfg_base_v),
        .cfg_base      (cfg_base),
        .cfg_stride_v  (cfg_stride_v),
        .cfg_stride    (cfg_stride),
        .cfg_stride_id (cfg_stride_id),
        .iter_v        (iter_v),
        .iter_last     (iter_last),
        .current_iters (current_iters),
        .addr_v        (addr_v),
        .addr          (addr),
        .addr_last     (addr_last),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_addr(input logic [IW*NL-1:0] its);
        logic [63:0] s;
        s = 64'(base_m);
        for (int l = 0; l < NL; l++) begin
            s = s + 64'(its[IW*l +: IW]) * 64'(stride_m[l]);
        end
        return s[31:0];
    endfunction

    // Reference model: decides acceptance from the block rules, config applied after the sample.
    always @(posedge clk) begin
        froze = stall && !start && !reset;
        if (reset) begin
            q.delete();
            run_m  = 0;
            base_m = 0;
            for (int i = 0; i < NL; i++) stride_m[i] = 0;
        end else begin
            if (start) begin
                q.delete();
                run_m = 1;
            end else if (run_m && iter_v && !stall) begin
                q.push_back('{a: model_addr(current_iters), last: iter_last});
                if (iter_last) run_m = 0;
            end
            if (cfg_base_v) base_m = cfg_base;
            if (cfg_stride_v) stride_m[cfg_stride_id] = cfg_stride;
        end
    end

    // Monitor: a beat is consumed when presented with stall low.
    always @(negedge clk) begin
        exp_t e;
        if (froze) begin
            total++;
            if (addr_v !== prev_v || addr !== prev_addr || addr_last !== prev_last) begin
                bad++;
                $display("FAIL stall_hold: got v=%b a=%h l=%b want v=%b a=%h l=%b",
                         addr_v, addr, addr_last, prev_v, prev_addr, prev_last);
            end
        end
        total++;
        if (done !== exp_done) begin
            bad++;
            $display("FAIL done_pulse at %0t: got %b want %b", $time, done, exp_done);
        end
        if (done === 1'b1) done_cnt++;
        exp_done = 0;
        if (addr_v === 1'b1 && !stall) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat at %0t: got addr=%h want none", $time, addr);
            end else begin
                e = q.pop_front();
                if (addr !== e.a || addr_last !== e.last) begin
                    bad++;
                    $display("FAIL beat at %0t: got addr=%h last=%b want addr=%h last=%b",
                             $time, addr, addr_last, e.a, e.last);
                end
                if (e.last && !start && !reset) exp_done = 1;
            end
            last_seen = addr;
            beats++;
        end
        prev_v    = addr_v;
        prev_addr = addr;
        prev_last = addr_last;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; cfg_base_v = 0; cfg_stride_v = 0; iter_v = 0; iter_last = 0;
    endtask

    task automatic set_iters(input int unsigned a, input int unsigned b,
                             input int unsigned c, input int unsigned d);
        current_iters = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    task automatic wr_base(input logic [31:0] v);
        cfg_base_v = 1; cfg_base = v; tick(); cfg_base_v = 0;
    endtask

    task automatic wr_stride(input int id, input logic [31:0] v);
        cfg_stride_v = 1; cfg_stride_id = 2'(id); cfg_stride = v; tick(); cfg_stride_v = 0;
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic sample(input int unsigned a, input int unsigned b, input int unsigned c,
                          input int unsigned d, input bit last);
        set_iters(a, b, c, d); iter_v = 1; iter_last = last; tick(); iter_v = 0; iter_last = 0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        int b0, d0;
        reset = 1; idle_inputs();
        cfg_base = 0; cfg_stride = 0; cfg_stride_id = 0; current_iters = 0;
        repeat (2) tick();
        reset = 0;
        chk("reset_addr_v", 32'(addr_v), 0);
        chk("reset_addr", addr, 0);
        chk("reset_addr_last", 32'(addr_last), 0);
        chk("reset_done", 32'(done), 0);

        // Mixed strides, two-cycle latency.
        wr_base(32'h1000);
        wr_stride(0, 1); wr_stride(1, 4); wr_stride(2, 16); wr_stride(3, 64);
        do_start();
        sample(3, 2, 1, 0, 0);
        tick();
        chk("t1_latency_v", 32'(addr_v), 1);
        chk("t1_addr", addr, 32'h101B);
        sample(0, 0, 0, 0, 1);
        drain(20);

        // Contiguous single-loop walk with done after the last beat.
        wr_stride(0, 4);
        b0 = beats; d0 = done_cnt;
        do_start();
        for (int i = 0; i < 8; i++) sample(i, 0, 0, 0, i == 7);
        drain(20);
        chk("t2_beats", 32'(beats - b0), 8);
        chk("t2_last_addr", last_seen, 32'h101C);
        chk("t2_done_cnt", 32'(done_cnt - d0), 1);

        // Three-cycle stall mid-stream with iter_v held high.
        b0 = beats;
        do_start();
        for (int i = 0; i < 8; i++) begin
            sample(i, 1, 0, 2, i == 7);
            if (i == 3) begin
                set_iters(9, 9, 9, 9); iter_v = 1; stall = 1;
                repeat (3) tick();
                stall = 0; iter_v = 0;
            end
        end
        drain(20);
        chk("t3_beats", 32'(beats - b0), 8);

        // Wrap-around and same-cycle stride write.
        wr_base(32'h1);
        wr_stride(0, 32'hFFFF_FFFF);
        do_start();
        sample(2, 0, 0, 0, 0);
        set_iters(3, 0, 0, 0); iter_v = 1;
        cfg_stride_v = 1; cfg_stride_id = 0; cfg_stride = 5;
        tick();
        iter_v = 0; cfg_stride_v = 0;
        chk("t4_wrap", addr, 32'hFFFF_FFFF);
        sample(3, 0, 0, 0, 1);
        chk("t4_old_stride", addr, 32'hFFFF_FFFE);
        drain(20);

        // Restart with two samples in flight.
        d0 = done_cnt;
        do_start();
        sample(1, 1, 1, 1, 0);
        sample(2, 2, 2, 2, 0);
        do_start();
        sample(7, 0, 0, 0, 0);
        sample(1, 0, 0, 0, 1);
        drain(20);
        chk("t5_done_cnt", 32'(done_cnt - d0), 1);

        // Reset while draining clears strides and base.
        do_start();
        sample(1, 0, 0, 0, 1);
        reset = 1; tick(); reset = 0;
        chk("t6_addr_v", 32'(addr_v), 0);
        chk("t6_done", 32'(done), 0);
        wr_base(32'h2000);
        do_start();
        sample(5, 6, 7, 8, 1);
        tick();
        chk("t6_addr_base", addr, 32'h2000);
        drain(20);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            if (!run_m && $urandom_range(3) == 0) start = 1;
            else if (run_m && $urandom_range(59) == 0) start = 1;
            if (!start) stall = ($urandom_range(3) == 0);
            iter_v    = ($urandom_range(3) != 0);
            iter_last = ($urandom_range(11) == 0);
            set_iters($urandom_range(16'hFFFF), $urandom_range(16'hFFFF),
                      $urandom_range(16'hFFFF), $urandom_range(16'hFFFF));
            if ($urandom_range(7) == 0) begin
                cfg_stride_v  = 1;
                cfg_stride_id = 2'($urandom_range(3));
                cfg_stride    = ($urandom_range(1) == 0) ? 32'($urandom_range(255)) : 32'($urandom);
            end
            if ($urandom_range(15) == 0) begin
                cfg_base_v = 1;
                cfg_base   = 32'($urandom);
            end
            tick();
        end
        idle_inputs();
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
